li_multi_input_shell: RTL and testbench
=======================================

# li_multi_input_shell

Parametrised latency-insensitive shell that joins NUM_IN input channels into a free-running pearl of fixed latency PEARL_LAT and returns results on one output channel. It is the successor of the single-link, clock-enabled shell. Each input has its own queue. Pearl firing is credit-based against an output queue, so downstream stop never gates the pearl clock and no combinational stop path reaches the pearl. The block sits between LI links and any fixed-latency datapath (FIR, MAC chains) in the shell layer.

## Interface
- NUM_IN, 2, number of input channels (≥1)
- DW_IN, 17, per-channel payload width (data plus embedded pearl valid bit)
- DW_OUT, 17, output payload width
- FIFO_ADDR, 2, input queue depth = 2^FIFO_ADDR
- STOP_MARGIN, 2, free slots reserved after stop is raised (1..2^FIFO_ADDR-1)
- PEARL_LAT, 3, pearl latency in cycles (≥1)
- OUT_ADDR, 3, output queue depth OUT_DEPTH = 2^OUT_ADDR
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_valid  in  NUM_IN  per-channel token valid
- i_data  in  NUM_IN*DW_IN  channel k at [k*DW_IN +: DW_IN]
- o_stop_up  out  NUM_IN  per-channel stop to upstream, registered
- o_pearl_fire  out  1  pearl input valid/strobe, registered
- o_pearl_data  out  NUM_IN*DW_IN  joined operands, registered, same packing as i_data
- i_pearl_data  in  DW_OUT  pearl result, sampled PEARL_LAT cycles after o_pearl_fire
- o_valid  out  1  output token valid
- o_data  out  DW_OUT  output token
- i_stop  in  1  downstream stop
- o_overflow  out  1  sticky: token arrived on a full input queue

## Operation
- Input queue k: enqueue when i_valid[k]=1. If queue is full, the token is dropped and o_overflow sets (sticky until reset).
- o_stop_up[k] is registered: next value = 1 when next-cycle occupancy ≥ 2^FIFO_ADDR − STOP_MARGIN.
- Credit counter, width OUT_ADDR+1, resets to OUT_DEPTH.
- fire = all input queues non-empty AND credits > 0.
- On fire: dequeue every input head. Next cycle: o_pearl_fire=1 and o_pearl_data=heads. Otherwise o_pearl_fire=0 and o_pearl_data holds its last value.
- Credits −1 on fire, +1 on output dequeue; both in the same cycle → unchanged. Credits never exceed OUT_DEPTH and never go below 0.
- PEARL_LAT-deep valid shift register is fed by o_pearl_fire. When its tail is 1, i_pearl_data is written into the output queue. This write can never overflow because of credits.
- Output: o_valid = output queue non-empty; o_data = queue head; dequeue when o_valid && !i_stop.
- Full-rate throughput requires OUT_DEPTH ≥ PEARL_LAT+3. Smaller depths are functionally correct but throttled.

## Timing
- Token on all inputs at cycle 0:
  - queues non-empty at cycle 1, fire at cycle 1
  - o_pearl_fire at cycle 2
  - result written at 2+PEARL_LAT
  - o_valid at 3+PEARL_LAT
- Total latency is PEARL_LAT+3 cycles.
- Simultaneous enqueue and dequeue on a full input queue: both take effect and occupancy is unchanged. The token is not dropped.
- Pointers wrap modulo depth; occupancy counters are one bit wider than the address.
- Reset values, with reset low at a clk edge (including mid-operation; all in-flight tokens are discarded):
  - queues empty
  - credits = OUT_DEPTH
  - shift register 0
  - o_pearl_fire 0, o_pearl_data 0
  - o_valid 0, o_stop_up 0, o_overflow 0
  - statistics counters 0

## Configuration
- LI_SHELL_STATS_EN defined: adds two ports, both saturating at all ones.
  - o_fire_count, out, 32: counts fires.
  - o_stall_count, out, 32: counts cycles with all inputs non-empty and credits = 0.
- LI_SHELL_STATS_EN undefined: those ports and their logic do not exist. Behaviour is otherwise identical.

## Structure
- Package li_shell_pkg holds:
  - credit-width and occupancy-width functions, e.g. ptr width = ADDR+1
  - the STATS_W=32 constant
- One sub-module, li_sync_fifo (WIDTH, ADDR; outputs occupancy, full, empty), instantiated NUM_IN times for the inputs and once for the output.
- Join logic, credit counter and valid shift register live in the top module.

## Test plan
- NUM_IN=2, PEARL_LAT=3, pearl modelled as a 3-stage delay of sum. Single token 5 and 7 at cycle 0 → o_valid=1 with o_data=12 at cycle 6 only.
- Channel 0 valid at cycle 0, channel 1 at cycle 4 → no o_pearl_fire before cycle 6; o_valid at cycle 10.
- Continuous tokens with i_stop=0 and OUT_DEPTH=8 → o_pearl_fire every cycle, no bubbles after the first output.
- Hold i_stop=1 for 20 cycles under continuous input:
  - exactly 8 pearl fires
  - o_stop_up asserts
  - no o_overflow
  - after i_stop drops, all tokens drain in order
- Ignore o_stop_up and push 5 tokens into a depth-4 queue while fire is blocked → o_overflow=1, remains set until reset.
- Pull reset low with 3 tokens in flight → next cycle o_valid=0, o_pearl_fire=0, credits restored; with stats enabled, o_fire_count=0.

Source files
------------

// File: rtl/li_shell_pkg.sv
// li_shell_pkg: shared width helpers and constants for the latency-insensitive shell
package li_shell_pkg;
  localparam int STATS_W = 32;
  function automatic int ptr_w(input int addr);
    return addr + 1;
  endfunction
  function automatic int credit_w(input int out_addr);
    return out_addr + 1;
  endfunction
endpackage

// File: rtl/li_sync_fifo.sv
// li_sync_fifo: synchronous FIFO with occupancy, full and empty flags; push on full is ignored unless a pop happens the same cycle
module li_sync_fifo import li_shell_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [ADDR:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int DEPTH = 1 << ADDR;
  localparam int CW = ptr_w(ADDR);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_wr, w_rd;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_data = r_mem[r_rd];
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

// File: rtl/li_multi_input_shell.sv
// li_multi_input_shell: joins NUM_IN LI channels into a free-running fixed-latency pearl using output-queue credits.
// Define LI_SHELL_STATS_EN to add saturating fire/stall counters.
module li_multi_input_shell import li_shell_pkg::*; #(
  parameter int NUM_IN      = 2,
  parameter int DW_IN       = 17,
  parameter int DW_OUT      = 17,
  parameter int FIFO_ADDR   = 2,
  parameter int STOP_MARGIN = 2,
  parameter int PEARL_LAT   = 3,
  parameter int OUT_ADDR    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       i_valid,
  input  logic [NUM_IN*DW_IN-1:0] i_data,
  output logic [NUM_IN-1:0]       o_stop_up,
  output logic                    o_pearl_fire,
  output logic [NUM_IN*DW_IN-1:0] o_pearl_data,
  input  logic [DW_OUT-1:0]       i_pearl_data,
  output logic                    o_valid,
  output logic [DW_OUT-1:0]       o_data,
  input  logic                    i_stop,
  output logic                    o_overflow
`ifdef LI_SHELL_STATS_EN
  ,
  output logic [STATS_W-1:0]      o_fire_count,
  output logic [STATS_W-1:0]      o_stall_count
`endif
);
  localparam int DEPTH = 1 << FIFO_ADDR;
  localparam int OUT_DEPTH = 1 << OUT_ADDR;
  localparam int QW = ptr_w(FIFO_ADDR);
  localparam int CW = credit_w(OUT_ADDR);
  localparam int STOP_TH = DEPTH - STOP_MARGIN;
  logic [NUM_IN-1:0] w_empty, w_full, w_ovf, w_stop_nxt;
  logic [QW-1:0] w_cnt [NUM_IN];
  logic [QW-1:0] w_nxt [NUM_IN];
  logic [NUM_IN*DW_IN-1:0] w_heads;
  logic [CW-1:0] r_credits, w_out_cnt;
  logic [PEARL_LAT-1:0] r_vsr;
  logic w_all, w_fire, w_tail, w_out_pop, w_out_full, w_out_empty;
  assign w_all = ~|w_empty;
  assign w_fire = w_all && (r_credits != '0);
  assign w_tail = r_vsr[PEARL_LAT-1];
  assign o_valid = !w_out_empty;
  assign w_out_pop = o_valid && !i_stop;
  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    li_sync_fifo #(.WIDTH(DW_IN), .ADDR(FIFO_ADDR)) u_q (
      .clk(clk), .reset(reset), .i_push(i_valid[g]), .i_pop(w_fire),
      .i_data(i_data[g*DW_IN +: DW_IN]), .o_data(w_heads[g*DW_IN +: DW_IN]),
      .o_count(w_cnt[g]), .o_full(w_full[g]), .o_empty(w_empty[g])
    );
    // a pop in the same cycle makes room, so a full queue still accepts
    assign w_nxt[g] = w_cnt[g] + QW'(i_valid[g] && (!w_full[g] || w_fire)) - QW'(w_fire);
    assign w_stop_nxt[g] = w_nxt[g] >= QW'(STOP_TH);
    assign w_ovf[g] = i_valid[g] && w_full[g] && !w_fire;
  end
  li_sync_fifo #(.WIDTH(DW_OUT), .ADDR(OUT_ADDR)) u_out (
    .clk(clk), .reset(reset), .i_push(w_tail), .i_pop(w_out_pop),
    .i_data(i_pearl_data), .o_data(o_data),
    .o_count(w_out_cnt), .o_full(w_out_full), .o_empty(w_out_empty)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credits <= CW'(OUT_DEPTH);
      r_vsr <= '0;
      o_pearl_fire <= 1'b0;
      o_pearl_data <= '0;
      o_stop_up <= '0;
      o_overflow <= 1'b0;
    end else begin
      r_credits <= r_credits - CW'(w_fire) + CW'(w_out_pop);
      r_vsr <= PEARL_LAT'({r_vsr, o_pearl_fire});
      o_pearl_fire <= w_fire;
      if (w_fire) o_pearl_data <= w_heads;
      o_stop_up <= w_stop_nxt;
      o_overflow <= o_overflow || |w_ovf;
    end
  end
  // every in-flight or queued result holds a credit, so the output queue never overflows
  a_out_room: assert property (@(posedge clk) disable iff (!reset) !(w_tail && w_out_full && !w_out_pop));
  a_credits: assert property (@(posedge clk) disable iff (!reset) ({1'b0, w_out_cnt} + {1'b0, r_credits}) <= (CW+1)'(OUT_DEPTH));
`ifdef LI_SHELL_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_fire_count <= '0;
      o_stall_count <= '0;
    end else begin
      if (w_fire && ~&o_fire_count) o_fire_count <= o_fire_count + 1'b1;
      if (w_all && r_credits == '0 && ~&o_stall_count) o_stall_count <= o_stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_li_multi_input_shell.sv
// tb_li_multi_input_shell: directed timing checks plus randomized traffic against a queue-based reference model
module tb_li_multi_input_shell;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] i_valid = '0;
  logic [33:0] i_data = '0;
  logic [1:0] o_stop_up;
  logic o_pearl_fire;
  logic [33:0] o_pearl_data;
  logic [16:0] i_pearl_data, p1 = '0, p2 = '0, p3 = '0;
  logic o_valid;
  logic [16:0] o_data;
  logic i_stop = 1'b0;
  logic o_overflow;
`ifdef LI_SHELL_STATS_EN
  logic [31:0] o_fire_count, o_stall_count;
`endif
  int n_chk = 0, n_bad = 0, n_fire = 0;
  bit sb_on = 1'b0;
  logic [16:0] q0[$], q1[$], qexp[$];
  logic s_valid, s_fire, s_ovf;
  logic [1:0] s_stop;
  logic [16:0] s_data;
  logic [33:0] s_pdata;

  li_multi_input_shell #(
    .NUM_IN(2), .DW_IN(17), .DW_OUT(17), .FIFO_ADDR(2),
    .STOP_MARGIN(2), .PEARL_LAT(3), .OUT_ADDR(3)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_stop_up(o_stop_up), .o_pearl_fire(o_pearl_fire), .o_pearl_data(o_pearl_data),
    .i_pearl_data(i_pearl_data), .o_valid(o_valid), .o_data(o_data),
    .i_stop(i_stop), .o_overflow(o_overflow)
`ifdef LI_SHELL_STATS_EN
    , .o_fire_count(o_fire_count), .o_stall_count(o_stall_count)
`endif
  );

  always #5 clk = ~clk;

  // pearl: three-stage delayed sum of the two operands
  always @(posedge clk) begin
    p1 <= o_pearl_data[16:0] + o_pearl_data[33:17];
    p2 <= p1;
    p3 <= p2;
  end
  assign i_pearl_data = p3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: the k-th result is the sum of the k-th token accepted on each channel
  task automatic put(input logic [1:0] v, input logic [16:0] a, input logic [16:0] b);
    logic [16:0] t0, t1, s;
    i_valid = v;
    i_data = {b, a};
    if (v[0]) q0.push_back(a);
    if (v[1]) q1.push_back(b);
    while (q0.size() > 0 && q1.size() > 0) begin
      t0 = q0.pop_front();
      t1 = q1.pop_front();
      s = t0 + t1;
      qexp.push_back(s);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_valid = o_valid;
    s_fire = o_pearl_fire;
    s_ovf = o_overflow;
    s_stop = o_stop_up;
    s_data = o_data;
    s_pdata = o_pearl_data;
    if (o_pearl_fire) n_fire++;
    if (sb_on && o_valid && !i_stop) begin
      if (qexp.size() == 0) check("sb_extra", 32'(qexp.size()), 32'd1);
      else check("sb_data", 32'(o_data), 32'(qexp.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    reset = 1'b0;
    i_valid = '0;
    i_stop = 1'b0;
    tick();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    qexp.delete();
    sb_on = 1'b1;
  endtask

  initial begin
    int bub;
    bit saw;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    tick();
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_fire", 32'(s_fire), 32'd0);
    check("rst_stop_up", 32'(s_stop), 32'd0);
    check("rst_ovf", 32'(s_ovf), 32'd0);
    check("rst_pdata", 32'(s_pdata), 32'd0);
    for (int c = 0; c < 11; c++) begin
      put(c == 0 ? 2'b11 : 2'b00, 17'd5, 17'd7);
      tick();
      check("t1_valid", 32'(s_valid), 32'(c == 6));
      check("t1_fire", 32'(s_fire), 32'(c == 2));
      if (c == 6) check("t1_data", 32'(s_data), 32'd12);
    end
    for (int c = 0; c < 12; c++) begin
      put({c == 4, c == 0}, 17'd100, 17'd23);
      tick();
      check("t2_fire", 32'(s_fire), 32'(c == 6));
      check("t2_valid", 32'(s_valid), 32'(c == 10));
    end
    n_fire = 0;
    bub = 0;
    for (int c = 0; c < 30; c++) begin
      put(~o_stop_up, 17'($urandom), 17'($urandom));
      tick();
      if (c > 6 && !s_valid) bub++;
    end
    check("t3_fires", 32'(n_fire), 32'd28);
    check("t3_bubbles", 32'(bub), 32'd0);
    put(2'b00, 17'd0, 17'd0);
    repeat (15) tick();
    check("t3_drain", 32'(qexp.size()), 32'd0);
    for (int c = 0; c < 6; c++) begin
      put(2'b11, 17'($urandom), 17'($urandom));
      tick();
    end
    put(2'b11, 17'd1, 17'd2);
    sb_on = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    put(2'b00, 17'd0, 17'd0);
    q0.delete();
    q1.delete();
    qexp.delete();
    sb_on = 1'b1;
    tick();
    check("rmid_valid", 32'(s_valid), 32'd0);
    check("rmid_fire", 32'(s_fire), 32'd0);
    check("rmid_stop_up", 32'(s_stop), 32'd0);
`ifdef LI_SHELL_STATS_EN
    check("rmid_fcnt", o_fire_count, 32'd0);
    check("rmid_scnt", o_stall_count, 32'd0);
`endif
    i_stop = 1'b1;
    n_fire = 0;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      put(~o_stop_up, 17'($urandom), 17'($urandom));
      tick();
      if (s_stop != 2'b00) saw = 1'b1;
    end
    check("t4_fires", 32'(n_fire), 32'd8);
    check("t4_stop_up", 32'(saw), 32'd1);
    check("t4_ovf", 32'(s_ovf), 32'd0);
`ifdef LI_SHELL_STATS_EN
    check("t4_fcnt", o_fire_count, 32'd8);
`endif
    i_stop = 1'b0;
    put(2'b00, 17'd0, 17'd0);
    repeat (30) tick();
    check("t4_drain", 32'(qexp.size()), 32'd0);
    do_reset();
    sb_on = 1'b0;
    for (int c = 0; c < 5; c++) begin
      put(2'b01, 17'(c), 17'd0);
      tick();
      check("t5_ovf_pre", 32'(s_ovf), 32'd0);
    end
    put(2'b00, 17'd0, 17'd0);
    tick();
    check("t5_ovf", 32'(s_ovf), 32'd1);
    check("t5_stop_up", 32'(s_stop[0]), 32'd1);
    repeat (5) tick();
    check("t5_sticky", 32'(s_ovf), 32'd1);
    do_reset();
    tick();
    check("t5_ovf_rst", 32'(s_ovf), 32'd0);
    for (int c = 0; c < 400; c++) begin
      put({!o_stop_up[1] && $urandom_range(3) != 0, !o_stop_up[0] && $urandom_range(3) != 0},
          17'($urandom), 17'($urandom));
      i_stop = $urandom_range(3) == 0;
      tick();
    end
    put(2'b00, 17'd0, 17'd0);
    i_stop = 1'b0;
    repeat (60) tick();
    check("rnd_drain", 32'(qexp.size()), 32'd0);
    check("rnd_ovf", 32'(s_ovf), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
